// File: rtl/counter.sv
// ---------------------------------------------------------------------------
// counter
// Free-running program-address counter for the RISC datapath. Advances by a
// fixed STEP on every rising clock edge and returns to RESET_VALUE on a
// synchronous active-high reset. The output feeds the instruction-fetch
// address directly from the register, with no branch or jump inputs.
// ---------------------------------------------------------------------------
module counter #(
    parameter int               WIDTH       = 32,
    // Typed parameters truncate overrides to WIDTH bits automatically.
    parameter logic [WIDTH-1:0] STEP        = WIDTH'(4),
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] out
);

    // NOTE: the declaration initializer gives the register its power-up value,
    // so the counter runs correctly even if reset is never asserted.
    logic [WIDTH-1:0] count = RESET_VALUE;

    // Load the start address on reset, otherwise advance one step; the add
    // wraps silently modulo 2^WIDTH and reset wins over the increment.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // flop samples its inputs from before the edge.
        if (reset) begin
            count <= RESET_VALUE;
        end else begin
            count <= count + STEP;
        end
    end

    assign out = count;

endmodule

// File: tb/tb_counter.sv
// ---------------------------------------------------------------------------
// tb_counter
// Self-checking bench for counter. Four instances (default, wrap-around start,
// 8-bit override, zero step) share one clock and have independent resets.
// Expected values come from the closed form RESET_VALUE + n*STEP mod 2^WIDTH,
// where n counts non-reset edges since the last reset edge (or power-up).
// ---------------------------------------------------------------------------
module tb_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b0;
    logic        rst1 = 1'b0;
    logic        rst2 = 1'b0;
    logic        rst3 = 1'b0;
    logic [31:0] out0;
    logic [31:0] out1;
    logic [7:0]  out2;
    logic [15:0] out3;

    counter #(.WIDTH(32), .STEP(32'd4), .RESET_VALUE(32'd0))
        u0 (.clk(clk), .reset(rst0), .out(out0));
    counter #(.WIDTH(32), .STEP(32'd4), .RESET_VALUE(32'hFFFF_FFF8))
        u1 (.clk(clk), .reset(rst1), .out(out1));
    counter #(.WIDTH(8), .STEP(8'd1), .RESET_VALUE(8'hFE))
        u2 (.clk(clk), .reset(rst2), .out(out2));
    counter #(.WIDTH(16), .STEP(16'd0), .RESET_VALUE(16'h1234))
        u3 (.clk(clk), .reset(rst3), .out(out3));

    int tests  = 0;
    int failed = 0;

    // Edges counted since the last reset edge, per instance.
    longint unsigned n [4] = '{0, 0, 0, 0};

    // Reference: start address plus n steps, reduced modulo 2^width.
    function automatic logic [63:0] model(input int idx);
        longint unsigned rv, st, w;
        case (idx)
            0:       begin rv = 64'h0;          st = 4; w = 32; end
            1:       begin rv = 64'hFFFF_FFF8;  st = 4; w = 32; end
            2:       begin rv = 64'hFE;         st = 1; w = 8;  end
            default: begin rv = 64'h1234;       st = 0; w = 16; end
        endcase
        return (rv + n[idx] * st) % (64'd1 << w);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model from the resets seen at the edge, then
    // compare every instance on the following falling edge.
    task automatic tick();
        logic [3:0] r;
        @(posedge clk);
        r = {rst3, rst2, rst1, rst0};
        for (int i = 0; i < 4; i++) begin
            if (r[i]) n[i] = 0;
            else      n[i] = n[i] + 1;
        end
        @(negedge clk);
        check("model_u0", {32'd0, out0}, model(0));
        check("model_u1", {32'd0, out1}, model(1));
        check("model_u2", {56'd0, out2}, model(2));
        check("model_u3", {48'd0, out3}, model(3));
    endtask

    initial begin
        // Power-up values before the first edge, reset never asserted.
        #1;
        check("powerup_u0", {32'd0, out0}, 64'h0);
        check("powerup_u1", {32'd0, out1}, 64'hFFFF_FFF8);
        check("powerup_u2", {56'd0, out2}, 64'hFE);
        check("powerup_u3", {48'd0, out3}, 64'h1234);

        tick(); check("count_4",  {32'd0, out0}, 64'd4);
        tick(); check("count_8",  {32'd0, out0}, 64'd8);
        tick(); check("count_12", {32'd0, out0}, 64'd12);
        repeat (7) tick();
        check("count_40", {32'd0, out0}, 64'd40);

        // Single-cycle reset takes effect only at the edge.
        rst0 = 1'b1;
        #1 check("rst_not_instant", {32'd0, out0}, 64'd40);
        tick(); check("rst_edge", {32'd0, out0}, 64'd0);
        rst0 = 1'b0;
        tick(); check("rst_resume", {32'd0, out0}, 64'd4);

        // Reset held three cycles.
        rst0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); check("rst_held", {32'd0, out0}, 64'd0);
        end
        rst0 = 1'b0;
        tick(); check("rst_held_resume", {32'd0, out0}, 64'd4);

        // Wrap-around from a high start address.
        rst1 = 1'b1;
        tick(); check("wrap_0", {32'd0, out1}, 64'hFFFF_FFF8);
        rst1 = 1'b0;
        tick(); check("wrap_1", {32'd0, out1}, 64'hFFFF_FFFC);
        tick(); check("wrap_2", {32'd0, out1}, 64'h0);
        tick(); check("wrap_3", {32'd0, out1}, 64'h4);

        // 8-bit parameter override.
        rst2 = 1'b1;
        tick(); check("w8_0", {56'd0, out2}, 64'hFE);
        rst2 = 1'b0;
        tick(); check("w8_1", {56'd0, out2}, 64'hFF);
        tick(); check("w8_2", {56'd0, out2}, 64'h00);
        tick(); check("w8_3", {56'd0, out2}, 64'h01);

        // Reset wins on the edge where the counter would wrap.
        rst1 = 1'b1; rst2 = 1'b1;
        tick();
        rst1 = 1'b0; rst2 = 1'b0;
        tick();
        check("prio_pre_u1", {32'd0, out1}, 64'hFFFF_FFFC);
        check("prio_pre_u2", {56'd0, out2}, 64'hFF);
        rst1 = 1'b1; rst2 = 1'b1;
        tick();
        check("prio_u1", {32'd0, out1}, 64'hFFFF_FFF8);
        check("prio_u2", {56'd0, out2}, 64'hFE);
        rst1 = 1'b0; rst2 = 1'b0;

        // A reset pulse between edges is ignored.
        tick();
        rst0 = 1'b1;
        #2 rst0 = 1'b0;
        tick();

        // Randomized resets, roughly one edge in eight per instance.
        repeat (300) begin
            rst0 = ($urandom_range(7) == 0);
            rst1 = ($urandom_range(7) == 0);
            rst2 = ($urandom_range(7) == 0);
            rst3 = ($urandom_range(7) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
